// File: rtl/reg_file_mp.sv
// ============================================================================
// Module      : reg_file_mp
// Description : Dual-write, dual-read register file with a self-clearing
//               sweep, optional write-to-read forwarding and zero entry 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp #(
    parameter int DW      = 8,
    parameter int PW      = 4,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en_a,
    input  logic [PW-1:0] wr_addr_a,
    input  logic [DW-1:0] dat_in_a,
    input  logic          wr_en_b,
    input  logic [PW-1:0] wr_addr_b,
    input  logic [DW-1:0] dat_in_b,
    input  logic [PW-1:0] rd_addr_a,
    input  logic [PW-1:0] rd_addr_b,
    output logic [DW-1:0] dat_a_out,
    output logic [DW-1:0] dat_b_out,
    input  logic          clr,
    output logic          busy,
    output logic          wr_drop
);

    localparam int            c_depth    = 2 ** PW;
    localparam logic [0:0]    c_idle     = 1'b0;
    localparam logic [0:0]    c_clear    = 1'b1;
    localparam logic [PW-1:0] c_idx_last = PW'(c_depth - 1);
    localparam logic [PW-1:0] c_idx_one  = PW'(1);

    logic [0:0]    r_state;
    logic [PW-1:0] r_idx;
    logic          r_busy;
    logic          r_wr_drop;
    logic [DW-1:0] r_core [c_depth];

    logic          w_we_a;
    logic          w_we_b;
    logic [DW-1:0] w_rd_a;
    logic [DW-1:0] w_rd_b;

    // A write to a hardwired-zero entry is treated as if it never happened.
    assign w_we_a = wr_en_a && !((R0_ZERO != 0) && (wr_addr_a == '0));
    assign w_we_b = wr_en_b && !((R0_ZERO != 0) && (wr_addr_b == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_clear;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_wr_drop <= 1'b0;
        end else if (r_state == c_clear) begin
            r_core[r_idx] <= '0;
            r_idx         <= r_idx + c_idx_one;
            r_wr_drop     <= w_we_a | w_we_b;
            if (r_idx == c_idx_last) begin
                r_state <= c_idle;
                r_busy  <= 1'b0;
            end
        end else begin
            r_wr_drop <= 1'b0;
            // Port B is written last so it wins on an address collision.
            if (w_we_a) r_core[wr_addr_a] <= dat_in_a;
            if (w_we_b) r_core[wr_addr_b] <= dat_in_b;
            if (clr) begin
                r_state <= c_clear;
                r_idx   <= '0;
                r_busy  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_a = r_core[rd_addr_a];
        w_rd_b = r_core[rd_addr_b];
        if (BYPASS != 0) begin
            if (w_we_a && (wr_addr_a == rd_addr_a)) w_rd_a = dat_in_a;
            if (w_we_b && (wr_addr_b == rd_addr_a)) w_rd_a = dat_in_b;
            if (w_we_a && (wr_addr_a == rd_addr_b)) w_rd_b = dat_in_a;
            if (w_we_b && (wr_addr_b == rd_addr_b)) w_rd_b = dat_in_b;
        end
        if ((R0_ZERO != 0) && (rd_addr_a == '0)) w_rd_a = '0;
        if ((R0_ZERO != 0) && (rd_addr_b == '0)) w_rd_b = '0;
        // Contents are mid-sweep while busy, so reads are masked.
        if (r_busy) begin
            w_rd_a = '0;
            w_rd_b = '0;
        end
    end

    assign dat_a_out = w_rd_a;
    assign dat_b_out = w_rd_b;
    assign busy      = r_busy;
    assign wr_drop   = r_wr_drop;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
// Module      : tb_reg_file_mp
// Description : Self-checking bench for reg_file_mp in three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

    localparam int DW    = 8;
    localparam int PW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clr = 1'b0;
    logic          wr_en_a = 1'b0;
    logic          wr_en_b = 1'b0;
    logic [PW-1:0] wr_addr_a = '0;
    logic [PW-1:0] wr_addr_b = '0;
    logic [PW-1:0] rd_addr_a = '0;
    logic [PW-1:0] rd_addr_b = '0;
    logic [DW-1:0] dat_in_a = '0;
    logic [DW-1:0] dat_in_b = '0;

    logic [DW-1:0] a1, b1, a2, b2, a3, b3;
    logic          busy1, drop1, busy2, drop2, busy3, drop3;
    logic [53:0]   act_vec;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DW(DW), .PW(PW), .BYPASS(1), .R0_ZERO(0)) u_byp (
        .clk(clk), .reset(reset),
        .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .dat_in_a(dat_in_a),
        .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .dat_in_b(dat_in_b),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .dat_a_out(a1), .dat_b_out(b1), .clr(clr), .busy(busy1), .wr_drop(drop1)
    );

    reg_file_mp #(.DW(DW), .PW(PW), .BYPASS(0), .R0_ZERO(0)) u_nobyp (
        .clk(clk), .reset(reset),
        .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .dat_in_a(dat_in_a),
        .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .dat_in_b(dat_in_b),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .dat_a_out(a2), .dat_b_out(b2), .clr(clr), .busy(busy2), .wr_drop(drop2)
    );

    reg_file_mp #(.DW(DW), .PW(PW), .BYPASS(1), .R0_ZERO(1)) u_r0 (
        .clk(clk), .reset(reset),
        .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .dat_in_a(dat_in_a),
        .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .dat_in_b(dat_in_b),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .dat_a_out(a3), .dat_b_out(b3), .clr(clr), .busy(busy3), .wr_drop(drop3)
    );

    assign act_vec = {a1, b1, busy1, drop1, a2, b2, busy2, drop2, a3, b3, busy3, drop3};

    // Reference: sweep is only visible as "busy for N cycles, then all zero".
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cnt = DEPTH;
    logic          m_drop = 1'b0;
    logic          m_drop_r0 = 1'b0;

    initial foreach (m_mem[i]) m_mem[i] = '0;

    function automatic logic [DW-1:0] exp_rd(input logic [PW-1:0] addr, input bit byp, input bit r0);
        if (m_cnt > 0) return '0;
        if (r0 && addr == '0) return '0;
        if (byp && wr_en_b && wr_addr_b == addr) return dat_in_b;
        if (byp && wr_en_a && wr_addr_a == addr) return dat_in_a;
        return m_mem[addr];
    endfunction

    function automatic logic [53:0] exp_vec();
        logic bz;
        bz = (m_cnt > 0);
        return {exp_rd(rd_addr_a, 1, 0), exp_rd(rd_addr_b, 1, 0), bz, m_drop,
                exp_rd(rd_addr_a, 0, 0), exp_rd(rd_addr_b, 0, 0), bz, m_drop,
                exp_rd(rd_addr_a, 1, 1), exp_rd(rd_addr_b, 1, 1), bz, m_drop_r0};
    endfunction

    function automatic void model_edge();
        if (reset) begin
            m_cnt = DEPTH; m_drop = 1'b0; m_drop_r0 = 1'b0;
        end else if (m_cnt > 0) begin
            m_drop    = wr_en_a | wr_en_b;
            m_drop_r0 = (wr_en_a && wr_addr_a != 0) || (wr_en_b && wr_addr_b != 0);
            m_cnt--;
            if (m_cnt == 0) foreach (m_mem[i]) m_mem[i] = '0;
        end else begin
            m_drop = 1'b0; m_drop_r0 = 1'b0;
            if (wr_en_a) m_mem[wr_addr_a] = dat_in_a;
            if (wr_en_b) m_mem[wr_addr_b] = dat_in_b;
            if (clr) m_cnt = DEPTH;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en_a = 1'b0; wr_en_b = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; idle_inputs();
        tick();
        reset = 1'b0;
        #4;
        total++;
        if ({a1, b1, busy1, drop1} !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
            bad++; $display("FAIL reset_state: got %h want %h", {a1, b1, busy1, drop1}, 18'h00002);
        end
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy1) break;
            n++;
            total++;
            if (act_vec !== exp_vec()) begin
                bad++; $display("FAIL reset_sweep: got %h want %h", act_vec, exp_vec());
            end
            tick(); #4;
        end
        total++;
        if (n != 16) begin
            bad++; $display("FAIL reset_busy_len: got %0d want 16", n);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr_a = PW'(i); rd_addr_b = PW'(DEPTH - 1 - i);
            #1;
            total++;
            if ({a1, b1, a2, b2} !== 32'h0) begin
                bad++; $display("FAIL reset_zero[%0d]: got %h want 0", i, {a1, b1, a2, b2});
            end
        end
        tick();
    endtask

    task automatic test_write_read();
        wr_en_a = 1'b1; wr_addr_a = 4'd3; dat_in_a = 8'hA5; rd_addr_a = 4'd3;
        #4;
        total++;
        if ({a1, a2, a3} !== {8'hA5, 8'h00, 8'hA5}) begin
            bad++; $display("FAIL wr_bypass: got %h want %h", {a1, a2, a3}, 24'hA500A5);
        end
        tick();
        idle_inputs();
        #4;
        total++;
        if ({a1, a2, a3} !== {8'hA5, 8'hA5, 8'hA5}) begin
            bad++; $display("FAIL wr_readback: got %h want %h", {a1, a2, a3}, 24'hA5A5A5);
        end
        tick();
    endtask

    task automatic test_same_addr();
        wr_en_a = 1'b1; wr_addr_a = 4'd7; dat_in_a = 8'h11;
        wr_en_b = 1'b1; wr_addr_b = 4'd7; dat_in_b = 8'h22;
        rd_addr_b = 4'd7;
        #4;
        total++;
        if ({b1, b2} !== {8'h22, 8'h00}) begin
            bad++; $display("FAIL collide_bypass: got %h want %h", {b1, b2}, 16'h2200);
        end
        tick();
        idle_inputs();
        #4;
        total++;
        if ({b1, b2, b3} !== {8'h22, 8'h22, 8'h22}) begin
            bad++; $display("FAIL collide_b_wins: got %h want %h", {b1, b2, b3}, 24'h222222);
        end
        tick();
    endtask

    task automatic wait_sweep(input string name);
        int n;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy1) break;
            n++;
            total++;
            if (act_vec !== exp_vec()) begin
                bad++; $display("FAIL %s_sweep: got %h want %h", name, act_vec, exp_vec());
            end
            tick(); #4;
        end
        total++;
        if (n != 16) begin
            bad++; $display("FAIL %s_busy_len: got %0d want 16", name, n);
        end
    endtask

    task automatic test_drop_busy();
        clr = 1'b1;
        #4;
        tick();
        clr = 1'b0; wr_en_b = 1'b1; wr_addr_b = 4'd2; dat_in_b = 8'h5A; rd_addr_a = 4'd2;
        #4;
        total++;
        if (act_vec !== exp_vec()) begin
            bad++; $display("FAIL drop_write: got %h want %h", act_vec, exp_vec());
        end
        tick();
        idle_inputs();
        #4;
        total++;
        if ({drop1, drop2, drop3, busy1} !== 4'b1111) begin
            bad++; $display("FAIL drop_pulse: got %b want 1111", {drop1, drop2, drop3, busy1});
        end
        tick(); #4;
        total++;
        if ({drop1, drop2, drop3} !== 3'b000) begin
            bad++; $display("FAIL drop_clears: got %b want 000", {drop1, drop2, drop3});
        end
        for (int c = 0; c < 40 && busy1; c++) begin tick(); #4; end
        total++;
        if ({busy1, a1, a2} !== 17'h0) begin
            bad++; $display("FAIL drop_addr2: got %h want 0", {busy1, a1, a2});
        end
        tick();
    endtask

    task automatic test_clr_with_write();
        for (int i = 0; i < DEPTH; i++) begin
            wr_en_a = 1'b1; wr_addr_a = PW'(i); dat_in_a = 8'hFF; rd_addr_b = PW'(i);
            #4;
            total++;
            if (act_vec !== exp_vec()) begin
                bad++; $display("FAIL fill[%0d]: got %h want %h", i, act_vec, exp_vec());
            end
            tick();
        end
        wr_en_a = 1'b1; wr_addr_a = 4'd9; dat_in_a = 8'h33; rd_addr_a = 4'd9; clr = 1'b1;
        #4;
        total++;
        if ({a1, a2} !== {8'h33, 8'hFF}) begin
            bad++; $display("FAIL clrwr_same: got %h want %h", {a1, a2}, 16'h33FF);
        end
        tick();
        idle_inputs();
        #4;
        wait_sweep("clrwr");
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr_a = PW'(i); rd_addr_b = PW'(i);
            #1;
            total++;
            if ({a1, b2, a3} !== 24'h0) begin
                bad++; $display("FAIL clrwr_zero[%0d]: got %h want 0", i, {a1, b2, a3});
            end
        end
        tick();
    endtask

    task automatic test_r0();
        wr_en_a = 1'b1; wr_addr_a = 4'd0; dat_in_a = 8'h77; rd_addr_a = 4'd0;
        #4;
        total++;
        if ({a1, a3} !== {8'h77, 8'h00}) begin
            bad++; $display("FAIL r0_bypass: got %h want %h", {a1, a3}, 16'h7700);
        end
        tick();
        idle_inputs();
        #4;
        total++;
        if ({a1, a3, drop3} !== {8'h77, 8'h00, 1'b0}) begin
            bad++; $display("FAIL r0_read: got %h want %h", {a1, a3, drop3}, 17'h0EE00);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #4;
        wait_sweep("r0_rst");
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            reset     = ($urandom % 250) == 0;
            clr       = ($urandom % 40) == 0;
            wr_en_a   = ($urandom % 3) == 0;
            wr_en_b   = ($urandom % 3) == 0;
            wr_addr_a = PW'($urandom);
            wr_addr_b = ($urandom % 4 == 0) ? wr_addr_a : PW'($urandom);
            dat_in_a  = DW'($urandom);
            dat_in_b  = DW'($urandom);
            rd_addr_a = ($urandom % 2 == 0) ? wr_addr_a : PW'($urandom);
            rd_addr_b = ($urandom % 2 == 0) ? wr_addr_b : PW'($urandom);
            #4;
            total++;
            if (act_vec !== exp_vec()) begin
                bad++; $display("FAIL random[%0d]: got %h want %h", c, act_vec, exp_vec());
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_addr();
        test_drop_busy();
        test_clr_with_write();
        test_r0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
